// File: rtl/fsm_pkg.sv
// Shared debounce state encoding and default sizing for the input stage.
// Optional auto-repeat is enabled by defining AUTOREPEAT_EN.
package fsm_pkg;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } dbnc_state_t;

    localparam int          DEF_CNT_W           = 24;
    localparam logic [23:0] DEF_DEBOUNCE_CYCLES = 24'd10_000_000;
    localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd5_000_000;
    localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd2_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-flop synchroniser, debounce FSM and stability counter.
// Define AUTOREPEAT_EN to add a held-button repeat counter.
module debounce_channel
    import fsm_pkg::*;
#(
    parameter int             CNT_W           = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(DEF_DEBOUNCE_CYCLES),
    parameter logic [CNT_W-1:0] REPEAT_DELAY    = CNT_W'(DEF_REPEAT_DELAY),
    parameter logic [CNT_W-1:0] REPEAT_PERIOD   = CNT_W'(DEF_REPEAT_PERIOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_nxt
);

    logic             sync1, sync2;
    dbnc_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             level_d, accept_d, rel_d;
    logic             rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        level_d  = level;
        accept_d = 1'b0;
        rel_d    = 1'b0;
        unique case (state)
            S_RELEASED: begin
                if (sync2) begin
                    state_d = S_PRESS_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_PRESS_PEND: begin
                if (!sync2) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else if (cnt == DEBOUNCE_CYCLES) begin
                    state_d  = S_PRESSED;
                    cnt_d    = '0;
                    level_d  = 1'b1;
                    accept_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!sync2) begin
                    state_d = S_RELEASE_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_RELEASE_PEND: begin
                if (sync2) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (cnt == DEBOUNCE_CYCLES) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef AUTOREPEAT_EN
    logic [CNT_W-1:0] rpt, rpt_d, rpt_tgt;
    logic             first, first_d;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_comb begin
        rpt_d    = rpt;
        first_d  = first;
        rpt_fire = 1'b0;
        rpt_tgt  = first ? REPEAT_DELAY - CNT_W'(1)
                         : REPEAT_PERIOD - CNT_W'(1);
        if (accept_d || state_d == S_RELEASED) begin
            rpt_d   = '0;
            first_d = 1'b1;
        end else if (state == S_PRESSED && sync2) begin
            if (rpt == rpt_tgt) begin
                rpt_fire = 1'b1;
                rpt_d    = '0;
                first_d  = 1'b0;
            end else begin
                rpt_d = rpt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt   <= '0;
            first <= 1'b1;
        end else begin
            rpt   <= rpt_d;
            first <= first_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire      = 1'b0;
`endif

    assign press_nxt = accept_d | rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            level <= level_d;
            press <= press_nxt;
            rel   <= rel_d;
        end
    end

endmodule

// File: rtl/btn_debounce_step.sv
// Debounced button front end: WIDTH independent channels plus any_press.
// Define AUTOREPEAT_EN to get auto-repeat press strobes on held buttons.
module btn_debounce_step
    import fsm_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               CNT_W           = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(DEF_DEBOUNCE_CYCLES),
    parameter logic [CNT_W-1:0] REPEAT_DELAY    = CNT_W'(DEF_REPEAT_DELAY),
    parameter logic [CNT_W-1:0] REPEAT_PERIOD   = CNT_W'(DEF_REPEAT_PERIOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             any_press
);

    logic [WIDTH-1:0] press_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn      (btn_in[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .rel      (btn_release[i]),
            .press_nxt(press_nxt[i])
        );
    end

    // Registered from the same next-state terms so it aligns with btn_press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce_step.sv
// Directed + random bench for btn_debounce_step against a run-length model.
module tb_btn_debounce_step;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_in = 8'h00;
    logic [7:0] btn_level, btn_press, btn_release;
    logic       any_press;

    int ncmp = 0;
    int nerr = 0;

    // Model: samples seen by channel logic lag btn_in by two edges;
    // a level is accepted after DEB+1 consecutive differing samples.
    logic [7:0] m_s1, m_s2, m_lvl, m_press, m_rel;
    int         run  [8];
    int         hold [8];

    btn_debounce_step #(
        .WIDTH          (8),
        .CNT_W          (24),
        .DEBOUNCE_CYCLES(24'd4),
        .REPEAT_DELAY   (24'd10),
        .REPEAT_PERIOD  (24'd3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_press  (any_press)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < 8; i++) begin
            run[i]  = 0;
            hold[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [7:0] v);
        logic [7:0] s;
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = v;
        for (int i = 0; i < 8; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            run[i] = (s[i] != m_lvl[i]) ? run[i] + 1 : 0;
            if (run[i] == DEB + 1) begin
                m_lvl[i] = s[i];
                run[i]   = 0;
                hold[i]  = 0;
                if (s[i]) m_press[i] = 1'b1;
                else      m_rel[i]   = 1'b1;
            end else if (m_lvl[i] && s[i]) begin
                hold[i]++;
`ifdef AUTOREPEAT_EN
                if (hold[i] == RD || (hold[i] > RD && (hold[i] - RD) % RP == 0))
                    m_press[i] = 1'b1;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".level"},   32'(btn_level),   32'(m_lvl));
        chk({tag, ".press"},   32'(btn_press),   32'(m_press));
        chk({tag, ".release"}, 32'(btn_release), 32'(m_rel));
        chk({tag, ".any"},     32'(any_press),   32'(|m_press));
    endtask

    task automatic tick(input string tag, input logic [7:0] v);
        btn_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        chk_all(tag);
    endtask

    initial begin
        int         first;
        logic [7:0] v;
        logic [7:0] pat;

        model_reset();
        btn_in = 8'hFF;
        repeat (3) @(negedge clk);
        chk_all("in_reset");
        rst_n = 1'b1;

        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("rst_all", 8'hFF);
            if (first == 0 && btn_press != 8'h00) first = k;
        end
        chk("rst_press_edge", 32'(first), 32'd7);
        for (int k = 0; k < 12; k++) tick("rel_all", 8'h00);

        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick("clean", 8'h01);
            if (first == 0 && btn_press[0]) first = k;
        end
        chk("clean_press_edge", 32'(first), 32'd7);

        pat = 8'b0000_0101;
        for (int k = 0; k < 4; k++) begin
            v    = 8'h01;
            v[2] = pat[k % 2];
            tick("bounce", v);
        end
        for (int k = 0; k < 10; k++) tick("bounce_hold", 8'h05);

        for (int k = 0; k < 10; k++) tick("ch3_press", 8'h0D);
        for (int k = 0; k < 2; k++)  tick("ch3_glitch", 8'h05);
        for (int k = 0; k < 10; k++) tick("ch3_back", 8'h0D);
        chk("ch3_kept", 32'(btn_level[3]), 32'd1);
        for (int k = 0; k < 10; k++) tick("ch3_release", 8'h05);

        for (int k = 0; k < 4; k++) tick("ch5_pend", 8'h25);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick("ch5_redo", 8'h25);
        for (int k = 0; k < 10; k++) tick("idle", 8'h00);

        for (int k = 0; k < 40; k++) tick("ch1_hold", 8'h02);
        for (int k = 0; k < 3; k++)  tick("ch1_bounce", 8'h00);
        for (int k = 0; k < 12; k++) tick("ch1_resume", 8'h02);
        for (int k = 0; k < 10; k++) tick("ch1_off", 8'h00);

        v = 8'h00;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            tick("random", v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
